// File: rtl/video_src_pkg.sv
// Shared constants for the frame-aligned two-source video scheduler.
package video_src_pkg;
  localparam int DW_DEF      = 32;
  localparam int FRAME_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_PASS = 2'd2
  } state_e;
endpackage

// File: rtl/video_src_sched_if.sv
// 4-pixel/beat video stream with line (h_last) and frame (v_last) markers.
// A beat transfers on a clock edge where tvalid && tready; the master holds tvalid, tdata and markers stable until then.
interface video_src_sched_if #(parameter int DW = video_src_pkg::DW_DEF);
  logic          tvalid;
  logic          tready;
  logic          h_last;
  logic          v_last;
  logic [DW-1:0] tdata;

  modport master (output tvalid, h_last, v_last, tdata, input tready);
  modport slave  (input tvalid, h_last, v_last, tdata, output tready);
endinterface

// File: rtl/axis_buf2.sv
// Two-entry FIFO register slice; head entry drives the output directly.
module axis_buf2 #(
  parameter int W = 34
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_ready,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem0, mem1;
  logic [1:0]   cnt;
  logic         rd, wr;

  assign full    = (cnt == 2'd2);
  assign empty   = (cnt == 2'd0);
  assign rd_data = mem0;
  assign rd      = !empty && rd_ready;
  // A write into a full buffer is only taken when the head leaves in the same cycle.
  assign wr      = wr_en && (!full || rd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= 2'd0;
      mem0 <= '0;
      mem1 <= '0;
    end else begin
      case ({rd, wr})
        2'b01: begin
          if (empty) mem0 <= wr_data;
          else       mem1 <= wr_data;
          cnt <= cnt + 2'd1;
        end
        2'b10: begin
          if (full) mem0 <= mem1;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          if (full) begin
            mem0 <= mem1;
            mem1 <= wr_data;
          end else begin
            mem0 <= wr_data;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/video_src_sched.sv
// Shares one output stream between two pixel sources, switching only on frame boundaries
// and resynchronising to a frame start after every switch.
module video_src_sched
  import video_src_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic                   data_clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   sel_req,
  input  logic                   clr_stat,
  video_src_sched_if.slave       s0,
  video_src_sched_if.slave       s1,
  video_src_sched_if.master      m,
  output logic                   cur_sel,
  output logic [1:0]             state,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   ovf
);
  state_e                 state_q, state_d;
  logic                   cur_sel_q, cur_sel_d;
  logic [1:0]             sof_flag_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_q;
  logic                   ovf_q;
  logic                   buf_full, buf_empty;
  logic [DW+1:0]          buf_rd_data;

  logic          sel_valid, sel_h_last, sel_v_last, sel_ready, sel_acc, boundary;
  logic [DW-1:0] sel_data;
  logic          in_pass, wr_en, ovf_set, out_frame_end;

  assign in_pass    = (state_q == ST_PASS);
  assign sel_valid  = cur_sel_q ? s1.tvalid : s0.tvalid;
  assign sel_h_last = cur_sel_q ? s1.h_last : s0.h_last;
  assign sel_v_last = cur_sel_q ? s1.v_last : s0.v_last;
  assign sel_data   = cur_sel_q ? s1.tdata  : s0.tdata;

  // Only the selected source in PASS is throttled, and only by the registered fill level.
  assign s0.tready  = !(in_pass && !cur_sel_q && buf_full);
  assign s1.tready  = !(in_pass &&  cur_sel_q && buf_full);
  assign sel_ready  = !(in_pass && buf_full);
  assign sel_acc    = sel_valid && sel_ready;
  assign boundary   = sel_acc && sel_v_last;
  assign wr_en      = in_pass && sel_acc;
  assign ovf_set    = in_pass && sel_valid && !sel_ready;

  always_comb begin
    state_d   = state_q;
    cur_sel_d = cur_sel_q;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          cur_sel_d = sel_req;
          state_d   = sof_flag_q[sel_req] ? ST_PASS : ST_SYNC;
        end
      end
      ST_SYNC: begin
        if (!en)           state_d = ST_IDLE;
        else if (boundary) state_d = ST_PASS;
      end
      ST_PASS: begin
        if (boundary) begin
          if (!en) begin
            state_d = ST_IDLE;
          end else if (sel_req != cur_sel_q) begin
            cur_sel_d = sel_req;
            state_d   = sof_flag_q[sel_req] ? ST_PASS : ST_SYNC;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge data_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cur_sel_q  <= 1'b0;
      sof_flag_q <= 2'b00;
    end else begin
      state_q   <= state_d;
      cur_sel_q <= cur_sel_d;
      // Frame-start tracking runs on both sources regardless of which one is forwarded.
      if (s0.tvalid && s0.tready) sof_flag_q[0] <= s0.v_last;
      if (s1.tvalid && s1.tready) sof_flag_q[1] <= s1.v_last;
    end
  end

  axis_buf2 #(.W(DW + 2)) u_buf (
    .clk      (data_clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  ({sel_h_last, sel_v_last, sel_data}),
    .rd_ready (m.tready),
    .rd_data  (buf_rd_data),
    .full     (buf_full),
    .empty    (buf_empty)
  );

  assign m.tvalid = !buf_empty;
  assign m.h_last = buf_rd_data[DW+1];
  assign m.v_last = buf_rd_data[DW];
  assign m.tdata  = buf_rd_data[DW-1:0];

  assign out_frame_end = m.tvalid && m.tready && m.v_last;

  // Set beats clear for ovf; clear beats increment for frame_cnt.
  always_ff @(posedge data_clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      if (ovf_set)       ovf_q <= 1'b1;
      else if (clr_stat) ovf_q <= 1'b0;
      if (clr_stat)           frame_cnt_q <= '0;
      else if (out_frame_end) frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
    end
  end

  assign cur_sel   = cur_sel_q;
  assign state     = state_q;
  assign frame_cnt = frame_cnt_q;
  assign ovf       = ovf_q;
endmodule
